// File: rtl/ctrl_step_sequencer_if.sv
// Control bundle between the step sequencer and the datapath: run/opcode in, strobes out.
// Handshake: run is a level, sampled only in IDLE and on the last step of an instruction; opcode is sampled on T2->T3.
interface ctrl_step_sequencer_if #(
  parameter int OPW = 5
);
  logic           run;
  logic [OPW-1:0] opcode;

  logic PC_out, Zlo_out, MDR_out, R_out, C_out, BAout;
  logic MAR_rd, Zlo_rd, PC_rd, MDR_rd, IR_rd, Y_rd, Rin;
  logic Gra, Grb, Grc, IncPC, Read, Write;
  logic [4:0] op_sel;
  logic [3:0] step;
  logic busy, halted, illegal;

  modport master (
    input  run, opcode,
    output PC_out, Zlo_out, MDR_out, R_out, C_out, BAout,
    output MAR_rd, Zlo_rd, PC_rd, MDR_rd, IR_rd, Y_rd, Rin,
    output Gra, Grb, Grc, IncPC, Read, Write,
    output op_sel, step, busy, halted, illegal
  );

  modport slave (
    output run, opcode,
    input  PC_out, Zlo_out, MDR_out, R_out, C_out, BAout,
    input  MAR_rd, Zlo_rd, PC_rd, MDR_rd, IR_rd, Y_rd, Rin,
    input  Gra, Grb, Grc, IncPC, Read, Write,
    input  op_sel, step, busy, halted, illegal
  );
endinterface

// File: rtl/ctrl_step_sequencer.sv
// Hardwired T-state sequencer: fetch T0-T2, execute T3-T7, with stretched memory steps.
// Every strobe is a registered Moore output decoded from the next state; step/halted expose the FSM state.
module ctrl_step_sequencer #(
  parameter int              OPW      = 5,
  parameter int              MEM_WAIT = 0,
  parameter logic [OPW-1:0]  OP_LD    = OPW'(0),
  parameter logic [OPW-1:0]  OP_LDI   = OPW'(1),
  parameter logic [OPW-1:0]  OP_ST    = OPW'(2),
  parameter logic [OPW-1:0]  ALU_R_LO = OPW'(3),
  parameter logic [OPW-1:0]  ALU_R_HI = OPW'(11),
  parameter logic [OPW-1:0]  OP_ADDI  = OPW'(12),
  parameter logic [OPW-1:0]  OP_ANDI  = OPW'(13),
  parameter logic [OPW-1:0]  OP_ORI   = OPW'(14),
  parameter logic [OPW-1:0]  OP_NOP   = OPW'(15),
  parameter logic [OPW-1:0]  OP_HALT  = OPW'(16),
  parameter logic [4:0]      ALU_ADD  = 5'd3,
  parameter logic [4:0]      ALU_AND  = 5'd5,
  parameter logic [4:0]      ALU_OR   = 5'd6
) (
  input  logic                     clk,
  input  logic                     clr,
  ctrl_step_sequencer_if.master    bus
);

  localparam int WCW = (MEM_WAIT > 0) ? $clog2(MEM_WAIT + 1) : 1;

  typedef enum logic [3:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_t;

  typedef enum logic [2:0] {
    C_LD, C_LDI, C_ST, C_ALUR, C_ALUI, C_NOP, C_HALT, C_ILL
  } cls_t;

  typedef struct packed {
    logic       pc_out, zlo_out, mdr_out, r_out, c_out, ba_out;
    logic       mar_rd, zlo_rd, pc_rd, mdr_rd, ir_rd, y_rd, rin;
    logic       gra, grb, grc, inc_pc, read, write;
    logic [4:0] op_sel;
    logic [3:0] step;
    logic       busy, halted, illegal;
  } out_t;

  localparam out_t OUT_RST = out_t'({24'd0, 4'hF, 3'd0});

  state_t         st_q, st_d;
  cls_t           cls_q, cls_d, dec_cls;
  logic [OPW-1:0] opc_q, opc_d;
  logic [WCW-1:0] wcnt_q, wcnt_d;
  out_t           out_q, out_d;
  logic           wait_done;
  logic           instr_end;

  // Opcode classification, used only on the T2->T3 edge.
  always_comb begin
    dec_cls = C_ILL;
    if (bus.opcode == OP_LD)        dec_cls = C_LD;
    else if (bus.opcode == OP_LDI)  dec_cls = C_LDI;
    else if (bus.opcode == OP_ST)   dec_cls = C_ST;
    else if (bus.opcode == OP_ADDI || bus.opcode == OP_ANDI || bus.opcode == OP_ORI)
                                    dec_cls = C_ALUI;
    else if (bus.opcode == OP_NOP)  dec_cls = C_NOP;
    else if (bus.opcode == OP_HALT) dec_cls = C_HALT;
    else if (bus.opcode >= ALU_R_LO && bus.opcode <= ALU_R_HI)
                                    dec_cls = C_ALUR;
  end

  // Next-state logic. The wait counter restarts on entry to every memory step.
  always_comb begin
    st_d      = st_q;
    cls_d     = cls_q;
    opc_d     = opc_q;
    wcnt_d    = wcnt_q;
    instr_end = 1'b0;
    wait_done = (wcnt_q == WCW'(MEM_WAIT));
    unique case (st_q)
      S_IDLE: if (bus.run) st_d = S_T0;
      S_T0: begin
        st_d   = S_T1;
        wcnt_d = '0;
      end
      S_T1: begin
        if (wait_done) st_d = S_T2;
        else           wcnt_d = wcnt_q + 1'b1;
      end
      S_T2: begin
        st_d  = S_T3;
        cls_d = dec_cls;
        opc_d = bus.opcode;
      end
      S_T3: begin
        unique case (cls_q)
          C_LD, C_LDI, C_ST, C_ALUR, C_ALUI: st_d = S_T4;
          C_HALT:                            st_d = S_HALT;
          default:                           instr_end = 1'b1;
        endcase
      end
      S_T4: st_d = S_T5;
      S_T5: begin
        if (cls_q == C_LD || cls_q == C_ST) begin
          st_d   = S_T6;
          wcnt_d = '0;
        end else begin
          instr_end = 1'b1;
        end
      end
      S_T6: begin
        if (cls_q == C_ST) begin
          st_d   = S_T7;
          wcnt_d = '0;
        end else if (wait_done) begin
          st_d = S_T7;
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
      end
      S_T7: begin
        if (cls_q == C_LD || wait_done) instr_end = 1'b1;
        else                            wcnt_d = wcnt_q + 1'b1;
      end
      S_HALT: st_d = S_HALT;
      default: st_d = S_IDLE;
    endcase
    // Back-to-back instructions start fetch without a bubble.
    if (instr_end) st_d = bus.run ? S_T0 : S_IDLE;
  end

  // Output decode from the next state, so the register holds them for the whole state.
  always_comb begin
    out_d = OUT_RST;
    unique case (st_d)
      S_IDLE: ;
      S_HALT: out_d.halted = 1'b1;
      S_T0: begin
        out_d.step   = 4'd0;
        out_d.busy   = 1'b1;
        out_d.pc_out = 1'b1;
        out_d.mar_rd = 1'b1;
        out_d.inc_pc = 1'b1;
        out_d.zlo_rd = 1'b1;
      end
      S_T1: begin
        out_d.step    = 4'd1;
        out_d.busy    = 1'b1;
        out_d.zlo_out = 1'b1;
        out_d.pc_rd   = 1'b1;
        out_d.read    = 1'b1;
        out_d.mdr_rd  = 1'b1;
      end
      S_T2: begin
        out_d.step    = 4'd2;
        out_d.busy    = 1'b1;
        out_d.mdr_out = 1'b1;
        out_d.ir_rd   = 1'b1;
      end
      S_T3: begin
        out_d.step = 4'd3;
        out_d.busy = 1'b1;
        unique case (cls_d)
          C_LD, C_LDI, C_ST: begin
            out_d.grb    = 1'b1;
            out_d.ba_out = 1'b1;
            out_d.r_out  = 1'b1;
            out_d.y_rd   = 1'b1;
          end
          C_ALUR, C_ALUI: begin
            out_d.grb   = 1'b1;
            out_d.r_out = 1'b1;
            out_d.y_rd  = 1'b1;
          end
          C_ILL:   out_d.illegal = 1'b1;
          default: ;
        endcase
      end
      S_T4: begin
        out_d.step   = 4'd4;
        out_d.busy   = 1'b1;
        out_d.zlo_rd = 1'b1;
        unique case (cls_d)
          C_ALUR: begin
            out_d.grc    = 1'b1;
            out_d.r_out  = 1'b1;
            out_d.op_sel = 5'(opc_d);
          end
          C_ALUI: begin
            out_d.c_out  = 1'b1;
            out_d.op_sel = (opc_d == OP_ADDI) ? ALU_ADD :
                           (opc_d == OP_ANDI) ? ALU_AND : ALU_OR;
          end
          default: begin
            out_d.c_out  = 1'b1;
            out_d.op_sel = ALU_ADD;
          end
        endcase
      end
      S_T5: begin
        out_d.step    = 4'd5;
        out_d.busy    = 1'b1;
        out_d.zlo_out = 1'b1;
        if (cls_d == C_LD || cls_d == C_ST) begin
          out_d.mar_rd = 1'b1;
        end else begin
          out_d.gra = 1'b1;
          out_d.rin = 1'b1;
        end
      end
      S_T6: begin
        out_d.step   = 4'd6;
        out_d.busy   = 1'b1;
        out_d.mdr_rd = 1'b1;
        if (cls_d == C_ST) begin
          out_d.gra   = 1'b1;
          out_d.r_out = 1'b1;
        end else begin
          out_d.read = 1'b1;
        end
      end
      S_T7: begin
        out_d.step = 4'd7;
        out_d.busy = 1'b1;
        if (cls_d == C_ST) begin
          out_d.write = 1'b1;
        end else begin
          out_d.mdr_out = 1'b1;
          out_d.gra     = 1'b1;
          out_d.rin     = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      st_q   <= S_IDLE;
      cls_q  <= C_NOP;
      opc_q  <= '0;
      wcnt_q <= '0;
      out_q  <= OUT_RST;
    end else begin
      st_q   <= st_d;
      cls_q  <= cls_d;
      opc_q  <= opc_d;
      wcnt_q <= wcnt_d;
      out_q  <= out_d;
    end
  end

  assign bus.PC_out  = out_q.pc_out;
  assign bus.Zlo_out = out_q.zlo_out;
  assign bus.MDR_out = out_q.mdr_out;
  assign bus.R_out   = out_q.r_out;
  assign bus.C_out   = out_q.c_out;
  assign bus.BAout   = out_q.ba_out;
  assign bus.MAR_rd  = out_q.mar_rd;
  assign bus.Zlo_rd  = out_q.zlo_rd;
  assign bus.PC_rd   = out_q.pc_rd;
  assign bus.MDR_rd  = out_q.mdr_rd;
  assign bus.IR_rd   = out_q.ir_rd;
  assign bus.Y_rd    = out_q.y_rd;
  assign bus.Rin     = out_q.rin;
  assign bus.Gra     = out_q.gra;
  assign bus.Grb     = out_q.grb;
  assign bus.Grc     = out_q.grc;
  assign bus.IncPC   = out_q.inc_pc;
  assign bus.Read    = out_q.read;
  assign bus.Write   = out_q.write;
  assign bus.op_sel  = out_q.op_sel;
  assign bus.step    = out_q.step;
  assign bus.busy    = out_q.busy;
  assign bus.halted  = out_q.halted;
  assign bus.illegal = out_q.illegal;

  // BAout only qualifies the Grb register read, so it is not counted as a separate bus driver.
  a_one_driver: assert property (@(posedge clk)
    $onehot0({out_q.pc_out, out_q.zlo_out, out_q.mdr_out, out_q.r_out, out_q.c_out}));
  a_rd_wr_excl: assert property (@(posedge clk) !(out_q.read && out_q.write));
  a_ba_with_grb: assert property (@(posedge clk)
    out_q.ba_out |-> (out_q.grb && out_q.r_out && !out_q.gra && !out_q.grc));

endmodule

// File: tb/tb_ctrl_step_sequencer.sv
// Bench for ctrl_step_sequencer: per-instruction trace model feeding an expected queue, checked every cycle,
// plus hand-computed literal spot checks. Two instances cover MEM_WAIT=0 and MEM_WAIT=2.
`timescale 1ns/1ps
module tb_ctrl_step_sequencer;

  localparam int W = 31;
  localparam int B_PC_OUT = 0,  B_ZLO_OUT = 1, B_MDR_OUT = 2, B_R_OUT = 3, B_C_OUT = 4, B_BA_OUT = 5;
  localparam int B_MAR_RD = 6,  B_ZLO_RD = 7,  B_PC_RD = 8,   B_MDR_RD = 9, B_IR_RD = 10, B_Y_RD = 11;
  localparam int B_RIN = 12,    B_GRA = 13,    B_GRB = 14,    B_GRC = 15,   B_INC_PC = 16;
  localparam int B_READ = 17,   B_WRITE = 18,  B_ILLEGAL = 19, B_HALTED = 20, B_BUSY = 21;
  localparam int B_STEP = 22,   B_OPS = 26;

  // clock / reset
  logic clk = 1'b0;
  logic clr0, clr2;
  always #5 clk = ~clk;

  ctrl_step_sequencer_if #(.OPW(5)) if0 ();
  ctrl_step_sequencer_if #(.OPW(5)) if2 ();

  ctrl_step_sequencer #(.MEM_WAIT(0)) dut0 (.clk(clk), .clr(clr0), .bus(if0.master));
  ctrl_step_sequencer #(.MEM_WAIT(2)) dut2 (.clk(clk), .clr(clr2), .bus(if2.master));

  logic [W-1:0] obs0, obs2;
  assign obs0 = {if0.op_sel, if0.step, if0.busy, if0.halted, if0.illegal, if0.Write, if0.Read,
                 if0.IncPC, if0.Grc, if0.Grb, if0.Gra, if0.Rin, if0.Y_rd, if0.IR_rd, if0.MDR_rd,
                 if0.PC_rd, if0.Zlo_rd, if0.MAR_rd, if0.BAout, if0.C_out, if0.R_out, if0.MDR_out,
                 if0.Zlo_out, if0.PC_out};
  assign obs2 = {if2.op_sel, if2.step, if2.busy, if2.halted, if2.illegal, if2.Write, if2.Read,
                 if2.IncPC, if2.Grc, if2.Grb, if2.Gra, if2.Rin, if2.Y_rd, if2.IR_rd, if2.MDR_rd,
                 if2.PC_rd, if2.Zlo_rd, if2.MAR_rd, if2.BAout, if2.C_out, if2.R_out, if2.MDR_out,
                 if2.Zlo_out, if2.PC_out};

  int errors = 0;
  int checks = 0;
  logic chk_en = 1'b0;
  logic [W-1:0] exp0_q[$];
  logic [W-1:0] exp2_q[$];
  logic [W-1:0] rest0, rest2, e0, e2;

  function automatic logic [W-1:0] sb(input int b);
    return W'(1) << b;
  endfunction

  function automatic logic [W-1:0] st(input int s);
    logic [W-1:0] w;
    w = W'(s) << B_STEP;
    if (s <= 7) w = w | sb(B_BUSY);
    return w;
  endfunction

  function automatic logic [W-1:0] ops(input int v);
    return W'(v) << B_OPS;
  endfunction

  localparam logic [W-1:0] STROBE_MASK = (W'(1) << 19) - W'(1);

  // Model: the cycle-by-cycle strobe trace an instruction must produce, pushed to the expected queue.
  task automatic push_instr(input int d, input logic [4:0] opc, input int mw, input int lim);
    logic [W-1:0] tr[$];
    int kind;
    int imm;
    if (opc == 5'd0)                       kind = 0;
    else if (opc == 5'd1)                  kind = 1;
    else if (opc == 5'd2)                  kind = 2;
    else if (opc >= 5'd3 && opc <= 5'd11)  kind = 3;
    else if (opc >= 5'd12 && opc <= 5'd14) kind = 4;
    else if (opc == 5'd15)                 kind = 5;
    else if (opc == 5'd16)                 kind = 6;
    else                                   kind = 7;
    imm = (opc == 5'd12) ? 3 : (opc == 5'd13) ? 5 : 6;
    tr.push_back(st(0) | sb(B_PC_OUT) | sb(B_MAR_RD) | sb(B_INC_PC) | sb(B_ZLO_RD));
    for (int i = 0; i <= mw; i++)
      tr.push_back(st(1) | sb(B_ZLO_OUT) | sb(B_PC_RD) | sb(B_READ) | sb(B_MDR_RD));
    tr.push_back(st(2) | sb(B_MDR_OUT) | sb(B_IR_RD));
    if (kind <= 2)      tr.push_back(st(3) | sb(B_GRB) | sb(B_BA_OUT) | sb(B_R_OUT) | sb(B_Y_RD));
    else if (kind <= 4) tr.push_back(st(3) | sb(B_GRB) | sb(B_R_OUT) | sb(B_Y_RD));
    else if (kind == 7) tr.push_back(st(3) | sb(B_ILLEGAL));
    else                tr.push_back(st(3));
    if (kind <= 2)      tr.push_back(st(4) | sb(B_C_OUT) | sb(B_ZLO_RD) | ops(3));
    else if (kind == 3) tr.push_back(st(4) | sb(B_GRC) | sb(B_R_OUT) | sb(B_ZLO_RD) | ops(int'(opc)));
    else if (kind == 4) tr.push_back(st(4) | sb(B_C_OUT) | sb(B_ZLO_RD) | ops(imm));
    if (kind == 0 || kind == 2) tr.push_back(st(5) | sb(B_ZLO_OUT) | sb(B_MAR_RD));
    else if (kind == 1 || kind == 3 || kind == 4)
      tr.push_back(st(5) | sb(B_ZLO_OUT) | sb(B_GRA) | sb(B_RIN));
    if (kind == 0) begin
      for (int i = 0; i <= mw; i++) tr.push_back(st(6) | sb(B_READ) | sb(B_MDR_RD));
      tr.push_back(st(7) | sb(B_MDR_OUT) | sb(B_GRA) | sb(B_RIN));
    end else if (kind == 2) begin
      tr.push_back(st(6) | sb(B_GRA) | sb(B_R_OUT) | sb(B_MDR_RD));
      for (int i = 0; i <= mw; i++) tr.push_back(st(7) | sb(B_WRITE));
    end
    if (kind == 6) begin
      if (d == 0) rest0 = st(15) | sb(B_HALTED);
      else        rest2 = st(15) | sb(B_HALTED);
    end
    for (int i = 0; i < tr.size(); i++) begin
      if (lim > 0 && i >= lim) break;
      if (d == 0) exp0_q.push_back(tr[i]);
      else        exp2_q.push_back(tr[i]);
    end
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // scoreboard: compare both instances every cycle
  always @(negedge clk) begin
    if (chk_en) begin
      e0 = (exp0_q.size() > 0) ? exp0_q.pop_front() : rest0;
      e2 = (exp2_q.size() > 0) ? exp2_q.pop_front() : rest2;
      checks += 2;
      if (obs0 !== e0) begin
        errors++;
        $display("FAIL trace0 got=%h exp=%h t=%0t", obs0, e0, $time);
      end
      if (obs2 !== e2) begin
        errors++;
        $display("FAIL trace2 got=%h exp=%h t=%0t", obs2, e2, $time);
      end
    end
  end

  // driver
  initial begin
    int rd_cnt, rin_cnt;
    clr0 = 1'b1; clr2 = 1'b1;
    if0.run = 1'b0; if0.opcode = 5'd0;
    if2.run = 1'b0; if2.opcode = 5'd0;
    rest0 = st(15); rest2 = st(15);
    cyc(2);
    clr0 = 1'b0; clr2 = 1'b0;
    chk_en = 1'b1;
    check("rst_step", 32'(if0.step), 32'd15);
    check("rst_busy_halt", 32'({if0.busy, if0.halted}), 32'd0);

    // st with MEM_WAIT=0
    if0.opcode = 5'd2; if0.run = 1'b1;
    cyc(1);
    if0.run = 1'b0;
    push_instr(0, 5'd2, 0, 0);
    cyc(4);
    check("st_t4_opsel", 32'(if0.op_sel), 32'd3);
    check("st_t4_cout", 32'(if0.C_out), 32'd1);
    cyc(2);
    check("st_t6", 32'({if0.Gra, if0.R_out, if0.MDR_rd}), 32'd7);
    cyc(1);
    check("st_t7_write", 32'(if0.Write), 32'd1);
    cyc(1);
    check("st_len_idle", 32'({if0.step, if0.Write}), 32'h1E);

    // two ALU instructions back-to-back: reg-form 4, then ori
    if0.opcode = 5'd4; if0.run = 1'b1;
    cyc(1);
    push_instr(0, 5'd4, 0, 0);
    push_instr(0, 5'd14, 0, 0);
    cyc(4);
    check("alur_t4_opsel", 32'(if0.op_sel), 32'd4);
    check("alur_t4_grc_rout", 32'({if0.Grc, if0.R_out}), 32'd3);
    if0.opcode = 5'd14;
    cyc(1);
    check("alur_t5_rin", 32'(if0.Rin), 32'd1);
    cyc(1);
    check("no_bubble_t0", 32'(if0.step), 32'd0);
    if0.run = 1'b0;
    cyc(4);
    check("ori_t4_opsel", 32'(if0.op_sel), 32'd6);
    check("ori_t4_cout", 32'(if0.C_out), 32'd1);
    cyc(2);
    check("ori_end_idle", 32'(if0.step), 32'd15);

    // unmapped opcode
    if0.opcode = 5'd20; if0.run = 1'b1;
    cyc(1);
    if0.run = 1'b0;
    push_instr(0, 5'd20, 0, 0);
    cyc(3);
    check("ill_t3_pulse", 32'({if0.step, if0.illegal}), 32'h7);
    cyc(1);
    check("ill_end_idle", 32'({if0.step, if0.illegal}), 32'h1E);

    // halt holds with run=1 until clr
    if0.opcode = 5'd16; if0.run = 1'b1;
    cyc(1);
    push_instr(0, 5'd16, 0, 0);
    cyc(4);
    check("halt_flag", 32'({if0.halted, if0.busy}), 32'h2);
    cyc(5);
    check("halt_stays", 32'({if0.halted, if0.step}), 32'h1F);
    clr0 = 1'b1; if0.run = 1'b0;
    cyc(1);
    rest0 = st(15);
    check("halt_clr", 32'(if0.halted), 32'd0);
    clr0 = 1'b0;

    // clr held 2 cycles during ld T4
    if0.opcode = 5'd0; if0.run = 1'b1;
    cyc(1);
    if0.run = 1'b0;
    push_instr(0, 5'd0, 0, 5);
    cyc(4);
    check("ld_t4_opsel", 32'(if0.op_sel), 32'd3);
    clr0 = 1'b1;
    cyc(1);
    check("clr_step_busy", 32'({if0.step, if0.busy}), 32'h1E);
    check("clr_strobes", 32'(obs0 & STROBE_MASK), 32'd0);
    cyc(1);
    clr0 = 1'b0;
    check("clr_opsel", 32'(if0.op_sel), 32'd0);

    // ld with MEM_WAIT=2
    if2.opcode = 5'd0; if2.run = 1'b1;
    cyc(1);
    if2.run = 1'b0;
    push_instr(2, 5'd0, 2, 0);
    rd_cnt = 0; rin_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      if (if2.Read && if2.MDR_rd) rd_cnt++;
      if (if2.Rin && if2.Gra) rin_cnt++;
      cyc(1);
    end
    check("ld_w2_read_cycles", 32'(rd_cnt), 32'd6);
    check("ld_w2_rin_cycles", 32'(rin_cnt), 32'd1);
    check("ld_w2_len_idle", 32'(if2.step), 32'd15);

    cyc(2);
    check("drain0", 32'(exp0_q.size()), 32'd0);
    check("drain2", 32'(exp2_q.size()), 32'd0);
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
